cut_bist_engine: RTL and testbench

- Built-in self-test engine for a 5-input / 2-output combinational circuit under test (CUT), such as the c17-class NAND benchmark netlists in the testability flow.
- Drives pseudo-random patterns into the CUT inputs from a Fibonacci LFSR.
- Compacts the CUT outputs into a multiple-input signature register (MISR) and compares the final signature against a golden value.
- Sits beside the CUT in the test wrapper: its pattern bus feeds the CUT inputs and the CUT outputs feed back into it.

---
 rtl/cut_bist_engine.sv | 89 ++++++++
 tb/tb_cut_bist_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_bist_engine.sv
// rtl/cut_bist_engine.sv - LFSR pattern generator + MISR compactor BIST engine for a small combinational CUT
// Optional macro BIST_ALLZERO_EN appends one all-zero pattern after the LFSR sequence.
module cut_bist_engine #(
  parameter int                 PAT_W        = 5,
  parameter int                 RESP_W       = 2,
  parameter int                 MISR_W       = 8,
  parameter int                 NUM_PATTERNS = 31,
  parameter logic [PAT_W-1:0]   LFSR_SEED    = PAT_W'(1),
  parameter logic [MISR_W-1:0]  MISR_POLY    = MISR_W'(8'h71),
  parameter logic [MISR_W-1:0]  GOLDEN_SIG   = '0,
  localparam int                CNT_W        = $clog2(NUM_PATTERNS + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  output logic [PAT_W-1:0]  pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  pat_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_LFSR_CNT = CNT_W'(NUM_PATTERNS - 1);
`ifdef BIST_ALLZERO_EN
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(NUM_PATTERNS);
`else
  localparam logic [CNT_W-1:0] FINAL_CNT = LAST_LFSR_CNT;
`endif

  state_t            state;
  logic [PAT_W-1:0]  lfsr_next;
  logic [MISR_W-1:0] sig_next;

  // pat_out doubles as the LFSR state register; it is forced to zero outside RUN.
  always_comb begin
    lfsr_next = {pat_out[PAT_W-2:0], pat_out[PAT_W-1] ^ pat_out[PAT_W-3]};
    sig_next  = {signature[MISR_W-2:0], 1'b0}
              ^ (signature[MISR_W-1] ? MISR_POLY : '0)
              ^ MISR_W'(resp_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_out   <= '0;
      signature <= '0;
      pat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pat_out   <= LFSR_SEED;
            signature <= '0;
            pat_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        RUN: begin
          signature <= sig_next;
          pat_cnt   <= pat_cnt + 1'b1;
          if (pat_cnt == FINAL_CNT) begin
            state   <= DONE;
            pat_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (sig_next == GOLDEN_SIG);
          end else if (pat_cnt == LAST_LFSR_CNT) begin
            // Extra cycle: present the all-zero vector the LFSR can never reach.
            pat_out <= '0;
          end else begin
            pat_out <= lfsr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cut_bist_engine.sv
// tb/tb_cut_bist_engine.sv - self-checking bench for cut_bist_engine with a c17 CUT model
// Honours BIST_ALLZERO_EN the same way as the design.
module tb_cut_bist_engine;

  localparam int         NP   = 31;
  localparam logic [4:0] SEED = 5'h01;
  localparam logic [7:0] POLY = 8'h71;
`ifdef BIST_ALLZERO_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int TOTAL = NP + EXTRA;

  function automatic logic [4:0] lfsr_nx(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = p;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // mode 0: c17, 1: c17 with N22 stuck-at-0, 2: all-zero responses, 3: 2'b11 on pattern 01 only
  function automatic logic [1:0] cut_resp(input int mode, input logic [4:0] p);
    logic [1:0] r;
    case (mode)
      0:       r = c17(p);
      1:       r = c17(p) & 2'b01;
      3:       r = (p == 5'h01) ? 2'b11 : 2'b00;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
    return {s[6:0], 1'b0} ^ (s[7] ? POLY : 8'h00) ^ {6'b0, r};
  endfunction

  function automatic logic [7:0] model_sig(input int mode);
    logic [4:0] q;
    logic [7:0] s;
    q = SEED;
    s = 8'h00;
    for (int i = 0; i < NP; i++) begin
      s = misr_step(s, cut_resp(mode, q));
      q = lfsr_nx(q);
    end
    if (EXTRA != 0) s = misr_step(s, cut_resp(mode, 5'h00));
    return s;
  endfunction

  localparam logic [7:0] GOLD = model_sig(0);

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] resp_in;
  logic [4:0] pat_out;
  logic       busy, done, pass;
  logic [7:0] signature;
  logic [5:0] pat_cnt;

  int         resp_mode = 2;
  int         checks = 0;
  int         errors = 0;
  int         run_cycles = 0;
  logic [4:0] patq[$];
  logic [4:0] seen[$];

  typedef struct {
    int         mode;
    logic [7:0] sig;
    logic       pass;
  } vec_t;
  vec_t vecs[4];

  cut_bist_engine #(
    .PAT_W(5), .RESP_W(2), .MISR_W(8), .NUM_PATTERNS(NP),
    .LFSR_SEED(SEED), .MISR_POLY(POLY), .GOLDEN_SIG(GOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_in),
    .pat_out(pat_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pat_cnt(pat_cnt)
  );

  always #5 clk = ~clk;

  always_comb resp_in = cut_resp(resp_mode, pat_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each RUN cycle pops the pattern the bench expects on the CUT inputs.
  always @(negedge clk) begin
    if (busy) begin
      run_cycles++;
      seen.push_back(pat_out);
      if (patq.size() == 0) chk("pat_queue_empty", 32'd1, 32'd0);
      else chk("pat_out", pat_out, patq.pop_front());
      chk("resp_known", $isunknown(resp_in), 32'd0);
    end
  end

  task automatic push_pats();
    logic [4:0] q;
    q = SEED;
    patq.delete();
    for (int i = 0; i < NP; i++) begin
      patq.push_back(q);
      q = lfsr_nx(q);
    end
    if (EXTRA != 0) patq.push_back(5'h00);
  endtask

  task automatic start_run(input int mode);
    resp_mode  = mode;
    push_pats();
    seen.delete();
    run_cycles = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 32'd1);
    chk("done_cleared", done, 32'd0);
    chk("pass_cleared", pass, 32'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", done, 32'd1);
  endtask

  task automatic check_result(input logic [7:0] exp_sig, input logic exp_pass);
    chk("signature", signature, exp_sig);
    chk("pass", pass, exp_pass);
    chk("pat_cnt", pat_cnt, TOTAL);
    chk("run_cycles", run_cycles, TOTAL);
    chk("busy_done", busy, 32'd0);
    chk("pat_out_done", pat_out, 32'd0);
    chk("queue_drained", patq.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp6[6];
    int zeros;
    exp6 = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};

    assert (SEED != 5'h00) else $fatal(1, "FAIL seed_nonzero: LFSR_SEED is zero");

    for (int i = 0; i < 4; i++) begin
      vecs[i].mode = i;
      vecs[i].sig  = (i == 2) ? 8'h00 : model_sig(i);
      vecs[i].pass = (vecs[i].sig == GOLD);
    end

    // Reset wins over start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_pat_out", pat_out, 32'd0);
    chk("rst_signature", signature, 32'd0);
    chk("rst_pat_cnt", pat_cnt, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_pass", pass, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 32'd0);
    chk("idle_done", done, 32'd0);

    // Table of full runs.
    for (int i = 0; i < 4; i++) begin
      start_run(vecs[i].mode);
      wait_done();
      check_result(vecs[i].sig, vecs[i].pass);
      if (i == 0) begin
        for (int k = 0; k < 6; k++) chk("pattern_seq", seen[k], exp6[k]);
        zeros = 0;
        for (int k = 0; k < NP; k++) if (seen[k] == 5'h00) zeros++;
        chk("no_zero_pattern", zeros, 32'd0);
      end
    end

    // MISR arithmetic on the first two edges.
    start_run(3);
    chk("misr_edge0", signature, 32'h00);
    @(negedge clk);
    chk("misr_edge1", signature, 32'h03);
    @(negedge clk);
    chk("misr_edge2", signature, 32'h06);
    wait_done();
    check_result(vecs[3].sig, vecs[3].pass);

    // start pulsed mid-run is ignored.
    start_run(0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_result(vecs[0].sig, vecs[0].pass);

    // Reset at pattern 10 discards the run.
    start_run(0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_signature", signature, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_done", done, 32'd0);
    chk("midrst_pat_cnt", pat_cnt, 32'd0);
    chk("midrst_pat_out", pat_out, 32'd0);
    patq.delete();
    @(negedge clk);
    chk("midrst_idle", busy, 32'd0);

    // Restart directly from DONE reproduces the same signature.
    start_run(0);
    wait_done();
    check_result(vecs[0].sig, vecs[0].pass);
    start_run(0);
    wait_done();
    check_result(vecs[0].sig, vecs[0].pass);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
